// File: rtl/xm23_pkg.sv
// Shared types and constants for the XM23 memory-access stage.
package xm23_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WB_ADDR = 2'd2,
        WB_DATA = 2'd3
    } mas_state_t;

    localparam logic [15:0] STEP_BYTE = 16'd1;
    localparam logic [15:0] STEP_WORD = 16'd2;

endpackage

// File: rtl/mas_addr_gen.sv
// Effective-address generator: base adjustment by byte/word step and
// pre/post selection of the address presented to memory.
module mas_addr_gen
    import xm23_pkg::*;
(
    input  logic [15:0] base_val,
    input  logic        WB,
    input  logic        PRPO,
    input  logic        INC,
    input  logic        DEC,
    output logic [15:0] ea,
    output logic [15:0] adj,
    output logic        illegal
);

    logic [15:0] step;

    always_comb begin
        step    = WB ? STEP_BYTE : STEP_WORD;
        illegal = INC & DEC;
        if (INC)
            adj = base_val + step;
        else if (DEC)
            adj = base_val - step;
        else
            adj = base_val;
        ea = PRPO ? adj : base_val;
    end

endmodule

// File: rtl/mem_access_stage.sv
// XM23 LD/ST memory-access stage: issues one req/ack transaction, then
// writes back the adjusted base and (for LD) the loaded data, stalling meanwhile.
module mem_access_stage
    import xm23_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        is_st,
    input  logic        WB,
    input  logic        PRPO,
    input  logic        DEC,
    input  logic        INC,
    input  logic [2:0]  base_sel,
    input  logic [2:0]  dst_sel,
    input  logic [15:0] base_val,
    input  logic [15:0] st_data,
    input  logic [15:0] dst_old,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        stall_o,
    output logic        reg_write_enable,
    output logic [3:0]  reg_write_select,
    output logic [15:0] reg_write_value,
    output logic        fault_o
);

    localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

    mas_state_t  state_reg;
    logic [15:0] ea;
    logic [15:0] adj;
    logic        illegal;

    logic        is_st_reg;
    logic        wb_reg;
    logic        adj_en_reg;
    logic        ea_lsb_reg;
    logic [2:0]  base_sel_reg;
    logic [2:0]  dst_sel_reg;
    logic [15:0] adj_reg;
    logic [15:0] dst_old_reg;
    logic [15:0] rdata_reg;
    logic [15:0] cnt_reg;
    logic [15:0] ld_value;

    mas_addr_gen u_addr_gen (
        .base_val (base_val),
        .WB       (WB),
        .PRPO     (PRPO),
        .INC      (INC),
        .DEC      (DEC),
        .ea       (ea),
        .adj      (adj),
        .illegal  (illegal)
    );

    // Byte loads replace only the low byte of the destination.
    always_comb begin
        if (wb_reg)
            ld_value = (dst_old_reg & 16'hFF00) |
                       {8'h00, (ea_lsb_reg ? rdata_reg[15:8] : rdata_reg[7:0])};
        else
            ld_value = rdata_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= 16'h0000;
            mem_be           <= 2'b00;
            mem_wdata        <= 16'h0000;
            stall_o          <= 1'b0;
            reg_write_enable <= 1'b0;
            reg_write_select <= 4'h0;
            reg_write_value  <= 16'h0000;
            fault_o          <= 1'b0;
            is_st_reg        <= 1'b0;
            wb_reg           <= 1'b0;
            adj_en_reg       <= 1'b0;
            ea_lsb_reg       <= 1'b0;
            base_sel_reg     <= 3'd0;
            dst_sel_reg      <= 3'd0;
            adj_reg          <= 16'h0000;
            dst_old_reg      <= 16'h0000;
            rdata_reg        <= 16'h0000;
            cnt_reg          <= 16'h0000;
        end else begin
            fault_o          <= 1'b0;
            reg_write_enable <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        if (illegal || (!WB && ea[0])) begin
                            fault_o <= 1'b1;
                        end else begin
                            is_st_reg    <= is_st;
                            wb_reg       <= WB;
                            adj_en_reg   <= INC | DEC;
                            ea_lsb_reg   <= ea[0];
                            base_sel_reg <= base_sel;
                            dst_sel_reg  <= dst_sel;
                            adj_reg      <= adj;
                            dst_old_reg  <= dst_old;
                            cnt_reg      <= 16'h0000;
                            mem_req      <= 1'b1;
                            mem_we       <= is_st;
                            mem_addr     <= ea;
                            mem_be       <= WB ? (ea[0] ? 2'b10 : 2'b01) : 2'b11;
                            mem_wdata    <= WB ? {2{st_data[7:0]}} : st_data;
                            stall_o      <= 1'b1;
                            state_reg    <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        rdata_reg <= mem_rdata;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        state_reg <= WB_ADDR;
                        if (adj_en_reg) begin
                            reg_write_enable <= 1'b1;
                            reg_write_select <= {1'b0, base_sel_reg};
                            reg_write_value  <= adj_reg;
                        end
                    end else if ((ACK_TIMEOUT != 0) && (cnt_reg == TO_LAST)) begin
                        fault_o   <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        stall_o   <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                WB_ADDR: begin
                    if (is_st_reg) begin
                        stall_o   <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        reg_write_enable <= 1'b1;
                        reg_write_select <= {1'b0, dst_sel_reg};
                        reg_write_value  <= ld_value;
                        state_reg        <= WB_DATA;
                    end
                end
                default: begin
                    stall_o   <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed table, reset abort
// sequence and randomized operations against an abstract register-file model.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, is_st, WB, PRPO, DEC, INC;
    logic [2:0]  base_sel, dst_sel;
    logic [15:0] base_val, st_data, dst_old;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [1:0]  mem_be;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        stall_o, reg_write_enable, fault_o;
    logic [3:0]  reg_write_select;
    logic [15:0] reg_write_value;

    int checks = 0;
    int errors = 0;

    logic [15:0] rf_obs [8];
    logic [15:0] rf_exp [8];

    typedef struct {
        logic        is_st, wb, prpo, dec, inc;
        logic [2:0]  base_sel, dst_sel;
        logic [15:0] base_val, st_data, dst_old, rdata;
        int          ack_delay;
        logic [15:0] exp_addr;
        logic [1:0]  exp_be;
        logic        exp_fault;
        logic [1:0]  exp_mask;
        logic [15:0] exp_rb, exp_rd;
    } vec_t;

    mem_access_stage #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .is_st(is_st), .WB(WB),
        .PRPO(PRPO), .DEC(DEC), .INC(INC), .base_sel(base_sel), .dst_sel(dst_sel),
        .base_val(base_val), .st_data(st_data), .dst_old(dst_old),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_o(stall_o), .reg_write_enable(reg_write_enable),
        .reg_write_select(reg_write_select), .reg_write_value(reg_write_value),
        .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          reqs = 0, faults = 0, stalls = 0, writes = 0;
        int          exp_reqs, exp_stalls, exp_writes, exp_faults;
        bit          done = 0, acc_fault, timeout;
        logic [15:0] step, adj, ea, exp_wdata, ldv;
        logic [1:0]  be;
        logic [15:0] first_addr = 16'h0;
        logic [1:0]  first_be = 2'b00;

        // Reference: plain arithmetic from the instruction rules.
        step      = v.wb ? 16'd1 : 16'd2;
        adj       = 16'((32'(v.base_val) + (v.inc ? 32'(step) : 0) - (v.dec ? 32'(step) : 0)) & 32'hFFFF);
        ea        = v.prpo ? adj : v.base_val;
        be        = v.wb ? (ea % 2 == 1 ? 2'b10 : 2'b01) : 2'b11;
        exp_wdata = v.wb ? 16'((v.st_data & 16'h00FF) * 16'd257) : v.st_data;
        acc_fault = (v.inc && v.dec) || (!v.wb && (ea % 2 == 1));
        timeout   = !acc_fault && (v.ack_delay < 0 || v.ack_delay + 1 > 4);
        if (acc_fault) begin
            exp_reqs = 0; exp_stalls = 0; exp_writes = 0; exp_faults = 1;
        end else if (timeout) begin
            exp_reqs = 4; exp_stalls = 4; exp_writes = 0; exp_faults = 1;
        end else begin
            exp_reqs   = v.ack_delay + 1;
            exp_writes = ((v.inc || v.dec) ? 1 : 0) + (v.is_st ? 0 : 1);
            exp_stalls = exp_reqs + 1 + (v.is_st ? 0 : 1);
            exp_faults = 0;
            if (v.inc || v.dec) rf_exp[v.base_sel] = adj;
            if (!v.is_st) begin
                if (v.wb)
                    ldv = (v.dst_old & 16'hFF00) | ((ea % 2 == 1) ? (v.rdata >> 8) : (v.rdata & 16'h00FF));
                else
                    ldv = v.rdata;
                rf_exp[v.dst_sel] = ldv;
            end
        end

        is_st = v.is_st; WB = v.wb; PRPO = v.prpo; DEC = v.dec; INC = v.inc;
        base_sel = v.base_sel; dst_sel = v.dst_sel; base_val = v.base_val;
        st_data = v.st_data; dst_old = v.dst_old; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (fault_o) faults++;
            if (stall_o) stalls++;
            if (reg_write_enable) begin
                writes++;
                rf_obs[reg_write_select[2:0]] = reg_write_value;
            end
            if (mem_req) begin
                reqs++;
                if (reqs == 1) begin
                    first_addr = mem_addr;
                    first_be   = mem_be;
                end
                chk({tag, " addr"}, 32'(mem_addr), 32'(ea));
                chk({tag, " be"}, 32'(mem_be), 32'(be));
                chk({tag, " wdata"}, 32'(mem_wdata), 32'(exp_wdata));
                chk({tag, " we"}, 32'(mem_we), 32'(v.is_st));
                mem_ack   = (v.ack_delay >= 0) && (reqs == v.ack_delay + 1);
                mem_rdata = mem_ack ? v.rdata : 16'($urandom);
            end else begin
                mem_ack   = ($urandom_range(0, 3) == 0);
                mem_rdata = 16'($urandom);
            end
            if (!stall_o) done = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk({tag, " finished"}, 32'(done), 32'd1);
        chk({tag, " fault"}, 32'(faults), 32'(exp_faults));
        chk({tag, " req_cycles"}, 32'(reqs), 32'(exp_reqs));
        chk({tag, " stall_cycles"}, 32'(stalls), 32'(exp_stalls));
        chk({tag, " writes"}, 32'(writes), 32'(exp_writes));
        for (int r = 0; r < 8; r++)
            if (rf_obs[r] !== rf_exp[r]) chk({tag, $sformatf(" R%0d", r)}, 32'(rf_obs[r]), 32'(rf_exp[r]));
        if (v.exp_mask != 2'b00 || v.exp_fault) begin
            chk({tag, " tbl_fault"}, 32'(faults), 32'(v.exp_fault));
            if (reqs > 0) begin
                chk({tag, " tbl_addr"}, 32'(first_addr), 32'(v.exp_addr));
                chk({tag, " tbl_be"}, 32'(first_be), 32'(v.exp_be));
            end
            if (v.exp_mask[0]) chk({tag, " tbl_Rbase"}, 32'(rf_obs[v.base_sel]), 32'(v.exp_rb));
            if (v.exp_mask[1]) chk({tag, " tbl_Rdst"}, 32'(rf_obs[v.dst_sel]), 32'(v.exp_rd));
        end
        $display("op %s st=%0b wb=%0b prpo=%0b inc=%0b dec=%0b base=%h ea=%h reqs=%0d writes=%0d fault=%0d",
                 tag, v.is_st, v.wb, v.prpo, v.inc, v.dec, v.base_val, ea, reqs, writes, faults);
        mem_ack = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " mem_req"}, 32'(mem_req), 0);
        chk({tag, " mem_we"}, 32'(mem_we), 0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 0);
        chk({tag, " mem_be"}, 32'(mem_be), 0);
        chk({tag, " mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, " stall"}, 32'(stall_o), 0);
        chk({tag, " rwe"}, 32'(reg_write_enable), 0);
        chk({tag, " rsel"}, 32'(reg_write_select), 0);
        chk({tag, " rval"}, 32'(reg_write_value), 0);
        chk({tag, " fault"}, 32'(fault_o), 0);
    endtask

    vec_t tbl [7];

    initial begin
        vec_t rv;
        int   busy;

        tbl[0] = '{0,0,0,0,1, 3'd1,3'd2, 16'h1000,16'h0000,16'h0000,16'hBEEF, 2, 16'h1000,2'b11,0, 2'b11,16'h1002,16'hBEEF};
        tbl[1] = '{1,1,1,1,0, 3'd3,3'd4, 16'h2001,16'h12AB,16'h0000,16'h0000, 0, 16'h2000,2'b01,0, 2'b01,16'h2000,16'h0000};
        tbl[2] = '{0,1,0,0,0, 3'd5,3'd6, 16'h3001,16'h0000,16'h55AA,16'h7F00, 0, 16'h3001,2'b10,0, 2'b10,16'h0000,16'h557F};
        tbl[3] = '{0,0,0,0,0, 3'd1,3'd2, 16'h0003,16'h0000,16'h0000,16'h1111, 0, 16'h0003,2'b11,1, 2'b00,16'h0000,16'h0000};
        tbl[4] = '{1,0,1,1,1, 3'd1,3'd2, 16'h0100,16'h4444,16'h0000,16'h0000, 0, 16'h0000,2'b11,1, 2'b00,16'h0000,16'h0000};
        tbl[5] = '{0,0,0,0,0, 3'd1,3'd3, 16'h5000,16'h0000,16'h0000,16'h2222,-1, 16'h5000,2'b11,1, 2'b00,16'h0000,16'h0000};
        tbl[6] = '{0,0,0,0,1, 3'd7,3'd7, 16'hFFFE,16'h0000,16'h0000,16'hCAFE, 1, 16'hFFFE,2'b11,0, 2'b11,16'hCAFE,16'hCAFE};

        for (int r = 0; r < 8; r++) begin
            rf_obs[r] = 16'h0;
            rf_exp[r] = 16'h0;
        end
        rst_n = 1'b0; in_valid = 1'b0; is_st = 0; WB = 0; PRPO = 0; DEC = 0; INC = 0;
        base_sel = 0; dst_sel = 0; base_val = 0; st_data = 0; dst_old = 0;
        mem_ack = 1'b0; mem_rdata = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("dir%0d", i));

        // Abort in the middle of a request: outputs clear at once, nothing written back.
        is_st = 0; WB = 0; PRPO = 0; DEC = 0; INC = 1; base_sel = 3'd2; dst_sel = 3'd4;
        base_val = 16'h4000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("abort in_req", 32'(mem_req), 1);
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("abort");
        @(posedge clk); #1;
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 16'h9999;
        busy = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (reg_write_enable || stall_o || mem_req) busy++;
        end
        mem_ack = 1'b0;
        chk("abort no_activity", 32'(busy), 0);
        $display("op abort reset during REQ, activity=%0d", busy);

        run_vec(tbl[6], "dir6");

        for (int i = 0; i < 60; i++) begin
            rv.is_st    = 1'($urandom);
            rv.wb       = 1'($urandom);
            rv.prpo     = 1'($urandom);
            rv.inc      = 1'($urandom);
            rv.dec      = ($urandom_range(0, 4) == 0) ? 1'b1 : (rv.inc ? 1'b0 : 1'($urandom));
            rv.base_sel = 3'($urandom);
            rv.dst_sel  = ($urandom_range(0, 5) == 0) ? rv.base_sel : 3'($urandom);
            case ($urandom_range(0, 3))
                0:       rv.base_val = 16'hFFFE + 16'($urandom_range(0, 3));
                default: rv.base_val = 16'($urandom);
            endcase
            if (!rv.wb && $urandom_range(0, 3) != 0) rv.base_val[0] = 1'b0;
            rv.st_data   = 16'($urandom);
            rv.dst_old   = 16'($urandom);
            rv.rdata     = 16'($urandom);
            rv.ack_delay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
            rv.exp_addr  = 16'h0;
            rv.exp_be    = 2'b00;
            rv.exp_fault = 1'b0;
            rv.exp_mask  = 2'b00;
            rv.exp_rb    = 16'h0;
            rv.exp_rd    = 16'h0;
            run_vec(rv, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
